// File: rtl/sp_ram_ctrl.sv
// Single-port synchronous RAM with valid/ready requests, per-byte write enables and a
// post-reset zero-fill. Define SP_RAM_PARITY_EN to add per-byte even parity and parity_err.
module sp_ram_ctrl #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
`ifdef SP_RAM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  init_done
);

    localparam int NB = DATA_W / 8;
`ifdef SP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                init_we;

    logic                in_range;
    logic                wr_en;
    logic                rd_en;

    logic                v1_reg;
    logic                oor1_reg;
    logic [DATA_W-1:0]   rd_word;

    logic                last_valid;
    logic                last_oor;
    logic [DATA_W-1:0]   last_data;

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0]       lane_err;
    logic                rd_err;
    logic                last_err;
`endif

    // FSM: zero-fill every word once after reset, then serve requests forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        init_we    = 1'b0;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_we = 1'b1;
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign wr_en    = req_valid & req_ready & req_we & in_range;
    assign rd_en    = req_valid & req_ready & ~req_we;

    // One narrow RAM per byte lane keeps byte enables a plain per-lane write enable
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [LANE_W-1:0] lane_mem [DEPTH];
        logic [LANE_W-1:0] lane_rd_reg;
        logic [LANE_W-1:0] lane_wr;
        logic [7:0]        wbyte;

        assign wbyte = req_wdata[8*gi +: 8];
`ifdef SP_RAM_PARITY_EN
        assign lane_wr = {^wbyte, wbyte};
        assign lane_err[gi] = ^lane_rd_reg;
`else
        assign lane_wr = wbyte;
`endif

        always_ff @(posedge clk) begin
            if (init_we) begin
                lane_mem[cnt_reg] <= '0;
            end else if (wr_en && req_be[gi]) begin
                lane_mem[req_addr] <= lane_wr;
            end
            if (rd_en && in_range) begin
                lane_rd_reg <= lane_mem[req_addr];
            end
        end

        assign rd_word[8*gi +: 8] = lane_rd_reg[7:0];
    end

`ifdef SP_RAM_PARITY_EN
    assign rd_err = (|lane_err) & ~oor1_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg   <= 1'b0;
            oor1_reg <= 1'b0;
        end else begin
            v1_reg   <= rd_en;
            oor1_reg <= rd_en & ~in_range;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              v2_reg;
        logic              oor2_reg;
        logic [DATA_W-1:0] d2_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_reg   <= 1'b0;
                oor2_reg <= 1'b0;
            end else begin
                v2_reg   <= v1_reg;
                oor2_reg <= oor1_reg;
            end
        end

        always_ff @(posedge clk) begin
            d2_reg <= rd_word;
        end

        assign last_valid = v2_reg;
        assign last_oor   = oor2_reg;
        assign last_data  = d2_reg;
`ifdef SP_RAM_PARITY_EN
        logic e2_reg;
        always_ff @(posedge clk) begin
            e2_reg <= rd_err;
        end
        assign last_err = e2_reg;
`endif
    end else begin : g_noreg
        assign last_valid = v1_reg;
        assign last_oor   = oor1_reg;
        assign last_data  = rd_word;
`ifdef SP_RAM_PARITY_EN
        assign last_err   = rd_err;
`endif
    end

    // Response register: holds the last read value between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= last_valid;
            if (last_valid) begin
                rsp_rdata <= last_oor ? '0 : last_data;
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= last_valid & last_err;
        end
    end
`endif

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed, table-driven bench for sp_ram_ctrl (DEPTH=8, DATA_W=128); read responses
// are checked for data and exact latency by a negedge monitor.
module tb_sp_ram_ctrl;

    localparam int DATA_W  = 128;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int OUT_REG = 0;
    localparam int LAT     = OUT_REG + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [DATA_W/8-1:0] req_be = '0;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                init_done;
`ifdef SP_RAM_PARITY_EN
    logic                parity_err;
`endif

    sp_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef SP_RAM_PARITY_EN
        .parity_err(parity_err),
`endif
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] be;
        logic [DATA_W-1:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding read
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: no response by cycle %0d, expected at %0d",
                         cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_spurious: rsp_valid=1 at cycle %0d with no read outstanding",
                             cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_latency", DATA_W'(cyc), DATA_W'(e.due));
                    chk("rsp_rdata", rsp_rdata, e.data);
`ifdef SP_RAM_PARITY_EN
                    chk("parity_err", DATA_W'(parity_err), DATA_W'(e.perr));
`endif
                    $display("rsp cycle=%0d data=%h", cyc, rsp_rdata);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic [DATA_W/8-1:0] be,
                      input logic [DATA_W-1:0] exp, input logic perr);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        chk("req_ready_run", DATA_W'(req_ready), DATA_W'(1));
        @(posedge clk);
        #1;
        $display("op cycle=%0d we=%0b addr=%0d wdata=%h be=%h", cyc, we, addr, wdata, be);
        if (!we) begin
            e.due  = cyc + LAT;
            e.data = exp;
            e.perr = perr;
            exp_q.push_back(e);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", DATA_W'(req_ready), DATA_W'(0));
        chk("rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_init_done", DATA_W'(init_done), DATA_W'(0));
`ifdef SP_RAM_PARITY_EN
        chk("rst_parity_err", DATA_W'(parity_err), DATA_W'(0));
`endif
        rst_n = 1'b1;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", DATA_W'(n), DATA_W'(DEPTH));
        chk("init_done", DATA_W'(init_done), DATA_W'(1));
        $display("init complete after %0d cycles", n);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] A5   = {16{8'hA5}};
    localparam logic [DATA_W-1:0] PAT  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DATA_W-1:0] PATM = 128'h01234567_00000000_FEDCBA98_00000000;
    localparam logic [DATA_W-1:0] DEAD = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [DATA_W-1:0] B0   = {120'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF, 8'h00};

    initial begin
        // reads of every address after reset
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back('{1'b0, ADDR_W'(i), '0, '0, '0});
        vecs.push_back('{1'b1, 3'd3, A5, 16'hFFFF, '0});
        vecs.push_back('{1'b0, 3'd3, '0, '0, A5});
        vecs.push_back('{1'b1, 3'd2, ALL1, 16'hFFFF, '0});
        vecs.push_back('{1'b1, 3'd2, '0, 16'h0001, '0});
        vecs.push_back('{1'b0, 3'd2, '0, '0, B0});
        vecs.push_back('{1'b1, 3'd5, PAT, 16'hF0F0, '0});
        vecs.push_back('{1'b0, 3'd5, '0, '0, PATM});
        vecs.push_back('{1'b1, 3'd5, ALL1, 16'h0000, '0});
        vecs.push_back('{1'b0, 3'd5, '0, '0, PATM});
        vecs.push_back('{1'b1, 3'd7, DEAD, 16'hFFFF, '0});
        vecs.push_back('{1'b0, 3'd7, '0, '0, DEAD});
        vecs.push_back('{1'b0, 3'd3, '0, '0, A5});
        vecs.push_back('{1'b0, 3'd0, '0, '0, '0});
        vecs.push_back('{1'b0, 3'd2, '0, '0, B0});

        do_reset();
        wait_init();

        for (int i = 0; i < vecs.size(); i++)
            op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, 1'b0);
        drain();
        chk("rdata_hold", rsp_rdata, B0);

        // reset with reads in flight: responses discarded, memory zero-filled again
        op(1'b0, 3'd7, '0, '0, DEAD, 1'b0);
        op(1'b0, 3'd3, '0, '0, A5, 1'b0);
        do_reset();
        wait_init();
        chk("post_rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        op(1'b0, 3'd7, '0, '0, '0, 1'b0);
        op(1'b0, 3'd3, '0, '0, '0, 1'b0);
        drain();

`ifdef SP_RAM_PARITY_EN
        op(1'b1, 3'd1, PAT, 16'hFFFF, '0, 1'b0);
        op(1'b0, 3'd1, '0, '0, PAT, 1'b0);
        drain();
        dut.g_lane[0].lane_mem[1][0] = ~dut.g_lane[0].lane_mem[1][0];
        op(1'b0, 3'd1, '0, '0, {PAT[127:1], ~PAT[0]}, 1'b1);
        op(1'b0, 3'd3, '0, '0, '0, 1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
